// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: expands one load/store-multiple into single-register micro-ops,
// issued lowest register first at ascending addresses, while holding fetch/decode.
module lm_sm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NREGS     = 8,
    parameter int IDX_W     = 3,
    parameter int ADDR_STEP = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [NREGS-1:0]  reg_mask,
    input  logic              hold,
    input  logic              flush,
    output logic              busy,
    output logic              stall_fetch,
    output logic              uop_valid,
    output logic              uop_is_store,
    output logic [IDX_W-1:0]  uop_reg,
    output logic [DATA_W-1:0] uop_addr,
    output logic              uop_last,
    output logic              done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NREGS-1:0]  rem_mask_q, rem_mask_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              op_q, op_d;
    logic              done_q, done_d;

    logic              in_seq;
    logic              accept;
    logic              fire;
    logic              is_last;
    logic [IDX_W-1:0]  low_idx;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREGS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [NREGS-1:0] m);
        return (m != '0) && ((m & (m - NREGS'(1))) == '0);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rem_mask_q <= '0;
            addr_q     <= '0;
            op_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        in_seq     = (state_q == SEQ);
        accept     = start & ~flush & ~in_seq;
        fire       = in_seq & ~hold & ~flush;
        is_last    = single_bit(rem_mask_q);
        low_idx    = lowest_idx(rem_mask_q);

        state_d    = state_q;
        rem_mask_d = rem_mask_q;
        addr_d     = addr_q;
        op_d       = op_q;
        done_d     = 1'b0;

        // Flush outranks both a new start and an in-flight sequence, and never signals done.
        if (flush) begin
            state_d    = IDLE;
            rem_mask_d = '0;
        end else if (accept) begin
            rem_mask_d = reg_mask;
            addr_d     = base_addr;
            op_d       = is_store;
            if (reg_mask != '0) state_d = SEQ;
            else                done_d  = 1'b1;
        end else if (fire) begin
            rem_mask_d = rem_mask_q & ~(NREGS'(1) << low_idx);
            addr_d     = addr_q + DATA_W'(ADDR_STEP);
            if (is_last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Gating with reset keeps stall_fetch low while reset is held, even if start is asserted.
    assign stall_fetch  = reset & ((accept & (reg_mask != '0)) | in_seq);
    assign busy         = in_seq;
    assign uop_valid    = fire;
    assign uop_is_store = in_seq & op_q;
    assign uop_reg      = in_seq ? low_idx : '0;
    assign uop_addr     = in_seq ? addr_q : '0;
    assign uop_last     = in_seq & is_last;
    assign done         = done_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed-vector bench for lm_sm_sequencer: each cycle drives inputs and compares the full output bundle.
module tb_lm_sm_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        hold;
    logic        flush;
    logic        busy;
    logic        stall_fetch;
    logic        uop_valid;
    logic        uop_is_store;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        uop_last;
    logic        done;

    int n_total = 0;
    int n_pass  = 0;

    lm_sm_sequencer #(
        .DATA_W   (16),
        .NREGS    (8),
        .IDX_W    (3),
        .ADDR_STEP(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .is_store    (is_store),
        .base_addr   (base_addr),
        .reg_mask    (reg_mask),
        .hold        (hold),
        .flush       (flush),
        .busy        (busy),
        .stall_fetch (stall_fetch),
        .uop_valid   (uop_valid),
        .uop_is_store(uop_is_store),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .uop_last    (uop_last),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {busy, stall_fetch, uop_valid, uop_is_store, uop_reg, uop_addr, uop_last, done}
    logic [24:0] obs;
    assign obs = {busy, stall_fetch, uop_valid, uop_is_store, uop_reg, uop_addr, uop_last, done};

    typedef struct {
        logic        st;
        logic        op;
        logic [15:0] base;
        logic [7:0]  mask;
        logic        hold;
        logic        flush;
        logic [24:0] exp;
    } vec_t;

    function automatic logic [24:0] E(input logic b, input logic s, input logic v, input logic st,
                                      input logic [2:0] r, input logic [15:0] a,
                                      input logic l, input logic d);
        return {b, s, v, st, r, a, l, d};
    endfunction

    localparam logic [24:0] ZERO = 25'h0;

    task automatic drive(input vec_t x);
        @(negedge clock);
        start     = x.st;
        is_store  = x.op;
        base_addr = x.base;
        reg_mask  = x.mask;
        hold      = x.hold;
        flush     = x.flush;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b1; is_store = 1'b1; base_addr = 16'h1234;
        reg_mask = 8'hFF; hold = 1'b0; flush = 1'b0;
        #1;
        n_total++;
        if (obs !== ZERO) $display("FAIL reset_t0: got %h want %h", obs, ZERO);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (obs !== ZERO) $display("FAIL reset_held: got %h want %h", obs, ZERO);
        else n_pass++;
        @(negedge clock);
        start = 1'b0; reg_mask = 8'h00; reset = 1'b1;
        #1;
        n_total++;
        if (obs !== ZERO) $display("FAIL reset_release: got %h want %h", obs, ZERO);
        else n_pass++;
    endtask

    task automatic test_lm_basic;
        vec_t v [0:6];
        v = '{
            '{1'b1, 1'b0, 16'h0040, 8'hA5, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd0,16'h0040,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd2,16'h0041,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd5,16'h0042,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd7,16'h0043,1'b1,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b1)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, ZERO}
        };
        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            n_total++;
            if (obs !== v[i].exp) $display("FAIL lm_basic cycle %0d: got %h want %h", i, obs, v[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_empty_mask;
        vec_t v [0:2];
        v = '{
            '{1'b1, 1'b1, 16'h0777, 8'h00, 1'b0, 1'b0, ZERO},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b1)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, ZERO}
        };
        for (int i = 0; i < 3; i++) begin
            drive(v[i]);
            n_total++;
            if (obs !== v[i].exp) $display("FAIL empty_mask cycle %0d: got %h want %h", i, obs, v[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_hold_wrap;
        vec_t v [0:12];
        v = '{
            '{1'b1, 1'b0, 16'hFFFE, 8'hFF, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd0,16'hFFFE,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, E(1'b1,1'b1,1'b0,1'b0,3'd1,16'hFFFF,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, E(1'b1,1'b1,1'b0,1'b0,3'd1,16'hFFFF,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd1,16'hFFFF,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd2,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd3,16'h0001,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd4,16'h0002,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd5,16'h0003,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd6,16'h0004,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd7,16'h0005,1'b1,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b1)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, ZERO}
        };
        for (int i = 0; i < 13; i++) begin
            drive(v[i]);
            n_total++;
            if (obs !== v[i].exp) $display("FAIL hold_wrap cycle %0d: got %h want %h", i, obs, v[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_flush;
        vec_t v [0:6];
        v = '{
            '{1'b1, 1'b1, 16'h0100, 8'h0F, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b1,3'd0,16'h0100,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, E(1'b1,1'b1,1'b0,1'b1,3'd1,16'h0101,1'b0,1'b0)},
            '{1'b1, 1'b0, 16'h0200, 8'h02, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd1,16'h0200,1'b1,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b1)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, ZERO}
        };
        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            n_total++;
            if (obs !== v[i].exp) $display("FAIL flush cycle %0d: got %h want %h", i, obs, v[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy;
        vec_t v [0:4];
        v = '{
            '{1'b1, 1'b1, 16'h0300, 8'h06, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b1, 1'b0, 16'h0AAA, 8'hFF, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b1,3'd1,16'h0300,1'b0,1'b0)},
            '{1'b1, 1'b0, 16'h0BBB, 8'h01, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b1,3'd2,16'h0301,1'b1,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b1)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, ZERO}
        };
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            n_total++;
            if (obs !== v[i].exp) $display("FAIL start_busy cycle %0d: got %h want %h", i, obs, v[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_seq;
        vec_t pre [0:2];
        vec_t post [0:3];
        pre = '{
            '{1'b1, 1'b0, 16'h0500, 8'h1F, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd0,16'h0500,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b0,3'd1,16'h0501,1'b0,1'b0)}
        };
        post = '{
            '{1'b1, 1'b1, 16'h0600, 8'h01, 1'b0, 1'b0, E(1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b1,1'b1,1'b1,1'b1,3'd0,16'h0600,1'b1,1'b0)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, E(1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b1)},
            '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, ZERO}
        };
        for (int i = 0; i < 3; i++) begin
            drive(pre[i]);
            n_total++;
            if (obs !== pre[i].exp) $display("FAIL rst_mid_pre cycle %0d: got %h want %h", i, obs, pre[i].exp);
            else n_pass++;
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_total++;
        if (obs !== ZERO) $display("FAIL rst_mid_async: got %h want %h", obs, ZERO);
        else n_pass++;
        @(posedge clock);
        #1;
        n_total++;
        if (obs !== ZERO) $display("FAIL rst_mid_held: got %h want %h", obs, ZERO);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_total++;
        if (obs !== ZERO) $display("FAIL rst_mid_release: got %h want %h", obs, ZERO);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(post[i]);
            n_total++;
            if (obs !== post[i].exp) $display("FAIL rst_mid_post cycle %0d: got %h want %h", i, obs, post[i].exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lm_basic();
        test_empty_mask();
        test_hold_wrap();
        test_flush();
        test_start_while_busy();
        test_reset_mid_seq();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
